// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Default divisor width. The derived constants below follow it.
  localparam int DEF_WIDTH = 2;

  // The step counter must hold 2*WIDTH, the number of quotient bits.
  localparam int CNT_W = $clog2(2 * DEF_WIDTH + 1);

  // Quotient reported when the divisor is zero.
  localparam logic [2*DEF_WIDTH-1:0] QUOT_ALL_ONES = {(2 * DEF_WIDTH){1'b1}};

  // Counter width for an arbitrary divisor width.
  function automatic int cnt_width(input int width);
    return $clog2(2 * width + 1);
  endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division step: shift {R,Q} left, trial-subtract the divisor,
// and keep the difference only when it is non-negative.
module divider_step #(
  parameter int WIDTH = 2
) (
  input  logic [3*WIDTH:0]   rq_i,
  input  logic [WIDTH-1:0]   divisor_i,
  output logic [3*WIDTH:0]   rq_o
);
  localparam int DW = 2 * WIDTH;

  logic [WIDTH:0]   r_in;
  logic [DW-1:0]    q_in;
  logic             r_hi;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   trial;
  logic             nonneg;

  // Combinational shift / trial-subtract / restore.
  always_comb begin
    r_in   = rq_i[3*WIDTH:DW];
    q_in   = rq_i[DW-1:0];
    // Bit shifted out of R. It is zero whenever R < divisor on entry, but it
    // is folded into the compare so the step stays correct for any R.
    r_hi   = r_in[WIDTH];
    r_sh   = {r_in[WIDTH-1:0], q_in[DW-1]};
    nonneg = r_hi | (r_sh >= {1'b0, divisor_i});
    trial  = r_sh - {1'b0, divisor_i};
    rq_o   = {(nonneg ? trial : r_sh), q_in[DW-2:0], nonneg};
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: 2*WIDTH-bit dividend by WIDTH-bit
// divisor, one quotient bit per clock, valid/ready handshake on both sides.
module seq_restoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_by_zero
);
  localparam int DW = 2 * WIDTH;
  localparam int RW = WIDTH + 1;
  localparam int CW = cnt_width(WIDTH);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   r_q, r_d;
  logic [DW-1:0]   q_q, q_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic            dbz_q, dbz_d;
  logic            ov_q, ov_d;
  logic [RW+DW-1:0] rq_nxt;

  divider_step #(.WIDTH(WIDTH)) u_step (
    .rq_i      ({r_q, q_q}),
    .divisor_i (div_q),
    .rq_o      (rq_nxt)
  );

  // Next-state logic for the FSM, step counter and result registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    div_d   = div_q;
    dbz_d   = dbz_q;
    ov_d    = ov_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          div_d = divisor;
          if (divisor != '0) begin
            state_d = ST_RUN;
            cnt_d   = CW'(DW);
            r_d     = '0;
            q_d     = dividend;
            dbz_d   = 1'b0;
          end else begin
            // No iteration needed: report the fixed divide-by-zero result.
            state_d = ST_DONE;
            q_d     = {DW{1'b1}};
            r_d     = {1'b0, dividend[WIDTH-1:0]};
            dbz_d   = 1'b1;
            ov_d    = 1'b1;
          end
        end
      end
      ST_RUN: begin
        {r_d, q_d} = rq_nxt;
        cnt_d      = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
          ov_d    = 1'b1;
        end
      end
      ST_DONE: begin
        // Result is held untouched until the consumer takes it.
        if (out_ready) begin
          state_d = ST_IDLE;
          ov_d    = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ov_d    = 1'b0;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      div_q   <= '0;
      dbz_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      div_q   <= div_d;
      dbz_q   <= dbz_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = ov_q;
  assign quotient    = q_q;
  assign remainder   = r_q[WIDTH-1:0];
  assign div_by_zero = dbz_q;

endmodule
